// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared constants for the unified memory stage: RV32I load/store
//            size codes and the access FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // RV32I funct3 size codes used by loads, stores and instruction fetch
    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    // Access FSM encoding
    typedef logic [1:0] mem_state_t;
    localparam mem_state_t IDLE = 2'd0;
    localparam mem_state_t WAIT = 2'd1;
    localparam mem_state_t RESP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mem_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_unit_if
// Purpose  : Request/response bus between the datapath address mux (master)
//            and the unified memory stage (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface mem_unit_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        busy;
    logic        misaligned;

    modport master (
        output req, we, funct3, addr, wdata,
        input  ready, rdata, busy, misaligned
    );

    modport slave (
        input  req, we, funct3, addr, wdata,
        output ready, rdata, busy, misaligned
    );
endinterface
`default_nettype wire

// File: rtl/mem_unit_ls_align.sv
`default_nettype none
// ============================================================================
// Module   : ls_align
// Purpose  : Combinational lane steering for RV32I accesses: byte enables and
//            replicated store data for writes, lane select plus sign/zero
//            extension for reads. Optional alignment checking is compiled in
//            with MEM_MISALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ls_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] raw_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] st_word_o,
    output logic [31:0] ld_val_o,
    output logic        misalign_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed lane, then build enables, store word and load value
    always_comb begin
        w_byte     = raw_i[{addr_lo_i, 3'b000} +: 8];
        w_half     = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
        misalign_o = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        case (funct3_i)
            LS_H, LS_HU: misalign_o = addr_lo_i[0];
            LS_W:        misalign_o = |addr_lo_i;
            default:     misalign_o = 1'b0;
        endcase
`endif
        be_o      = 4'b0000;
        st_word_o = wdata_i;
        ld_val_o  = 32'h0;
        // Store data is replicated across lanes so the enables alone pick the target
        case (funct3_i)
            LS_B: begin
                ld_val_o  = {{24{w_byte[7]}}, w_byte};
                be_o      = 4'b0001 << addr_lo_i;
                st_word_o = {4{wdata_i[7:0]}};
            end
            LS_BU: ld_val_o = {24'h0, w_byte};
            LS_H: begin
                ld_val_o  = {{16{w_half[15]}}, w_half};
                be_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                st_word_o = {2{wdata_i[15:0]}};
            end
            LS_HU: ld_val_o = {16'h0, w_half};
            LS_W: begin
                ld_val_o  = raw_i;
                be_o      = 4'b1111;
                st_word_o = wdata_i;
            end
            default: ld_val_o = 32'h0;
        endcase
        // A faulting access neither writes nor returns data
        if (misalign_o) begin
            be_o     = 4'b0000;
            ld_val_o = 32'h0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_unit
// Purpose  : Unified instruction/data memory with a req/ready handshake,
//            WAIT_CYCLES programmable stall, RV32I sizing and sign extension.
//            Optional alignment fault checking: define MEM_MISALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_unit
    import mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    mem_unit_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    mem_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [AW+1:0] addr_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        mis_q;

    logic [AW-1:0] w_idx;
    logic        w_access;
    logic [3:0]  w_be;
    logic [31:0] w_st;
    logic [31:0] w_ld;
    logic        w_mis;
    logic        unused_addr_hi;

    // Upper address bits deliberately fold back into the array (wrap modulo DEPTH)
    assign unused_addr_hi = ^bus.addr[31:AW+2];

    assign w_idx    = addr_q[AW+1:2];
    assign w_access = (state_q == WAIT) && (cnt_q == 4'd0);

    ls_align u_align (
        .funct3_i   (f3_q),
        .addr_lo_i  (addr_q[1:0]),
        .raw_i      (mem[w_idx]),
        .wdata_i    (wdata_q),
        .be_o       (w_be),
        .st_word_o  (w_st),
        .ld_val_o   (w_ld),
        .misalign_o (w_mis)
    );

    // Next-state and wait-counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    state_d = WAIT;
                    cnt_d   = 4'(WAIT_CYCLES);
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request capture in IDLE, and load result/fault registration
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && bus.req) begin
                addr_q  <= bus.addr[AW+1:0];
                we_q    <= bus.we;
                f3_q    <= bus.funct3;
                wdata_q <= bus.wdata;
            end
            if (w_access) begin
                mis_q <= w_mis;
                if (!we_q) rdata_q <= w_ld;
            end
        end
    end

    // Byte-lane store commit; reset forces IDLE so an aborted access never writes
    always_ff @(posedge clk) begin
        if (w_access && we_q) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) mem[w_idx][8*i +: 8] <= w_st[8*i +: 8];
            end
        end
    end

    assign bus.ready      = (state_q == RESP);
    assign bus.busy       = (state_q == WAIT);
    assign bus.rdata      = rdata_q;
    assign bus.misaligned = (state_q == RESP) && mis_q;

endmodule
`default_nettype wire
